sv_alu_sequencer: RTL and testbench

//   Upstream command stage for the 2-bit-opcode combinational ALU (00 ADD, 01 SUB, 10 AND, 11 OR).

---
 rtl/sv_alu_sequencer_if.sv | 27 ++
 rtl/sv_alu_sequencer.sv | 74 +++++++
 tb/tb_sv_alu_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sv_alu_sequencer_if.sv
// sv_alu_sequencer_if: command and response channels of the ALU sequencer.
// out_zero exists only when SV_ALU_SEQ_FLAGS_EN is defined.
interface sv_alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef SV_ALU_SEQ_FLAGS_EN
    logic             out_zero;
    modport master (output cmd_valid, cmd_load, cmd_op, cmd_data, out_ready,
                    input  cmd_ready, out_valid, out_data, busy, out_zero);
    modport slave  (input  cmd_valid, cmd_load, cmd_op, cmd_data, out_ready,
                    output cmd_ready, out_valid, out_data, busy, out_zero);
`else
    modport master (output cmd_valid, cmd_load, cmd_op, cmd_data, out_ready,
                    input  cmd_ready, out_valid, out_data, busy);
    modport slave  (input  cmd_valid, cmd_load, cmd_op, cmd_data, out_ready,
                    output cmd_ready, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/sv_alu_sequencer.sv
// sv_alu_sequencer: FIFO-buffered command sequencer driving an external ALU around an accumulator.
// Define SV_ALU_SEQ_FLAGS_EN to add the registered out_zero flag.
module sv_alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sv_alu_sequencer_if.slave bus,
    output logic [1:0]        alu_op_o,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    input  logic [WIDTH-1:0]  alu_res_i
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef struct packed {
        logic             load;
        logic [1:0]       op;
        logic [WIDTH-1:0] data;
    } cmd_t;
    cmd_t             mem_q [DEPTH];
    cmd_t             cmd_q, cmd_d;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    state_t           state_q, state_d;
    logic             full, empty, push, pop;
    assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty = wr_q == rd_q;
    always_comb begin
        push    = bus.cmd_valid && !full;
        pop     = state_q == IDLE && !empty;
        wr_d    = wr_q + (AW+1)'(push);
        rd_d    = rd_q + (AW+1)'(pop);
        cmd_d   = pop ? mem_q[rd_q[AW-1:0]] : cmd_q;
        acc_d   = state_q == ISSUE ? (cmd_q.load ? cmd_q.data : alu_res_i) : acc_q;
        state_d = state_q == IDLE  ? (empty ? IDLE : ISSUE) :
                  state_q == ISSUE ? RESP : (bus.out_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cmd_q   <= '0;
            acc_q   <= '0;
            state_q <= IDLE;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cmd_q   <= cmd_d;
            acc_q   <= acc_d;
            state_q <= state_d;
        end
    end
    // storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {bus.cmd_load, bus.cmd_op, bus.cmd_data};
    end
`ifdef SV_ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d;
    assign zero_d = state_q == ISSUE ? acc_d == '0 : zero_q;
    always_ff @(posedge clk) begin
        zero_q <= rst ? 1'b1 : zero_d;
    end
    assign bus.out_zero = zero_q;
`endif
    assign bus.cmd_ready = !full;
    assign bus.out_valid = state_q == RESP;
    assign bus.out_data  = acc_q;
    assign bus.busy      = state_q != IDLE || !empty;
    assign alu_op_o      = cmd_q.op;
    assign alu_a_o       = acc_q;
    assign alu_b_o       = cmd_q.data;
endmodule

// File: tb/tb_sv_alu_sequencer.sv
// tb_sv_alu_sequencer: closes the loop with an 8-bit ALU and checks responses against an accumulator model.
module tb_sv_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_res;
    int         n_chk = 0, n_pass = 0, n_acc = 0, n_rsp = 0;
    logic [7:0] acc_m = 8'h00, held = 8'h00, last_rsp = 8'h00;
    logic       stall = 1'b0;
    logic [7:0] exp_q[$];

    sv_alu_sequencer_if #(.WIDTH(8)) bus ();

    sv_alu_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_res_i(alu_res)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = alu_op == 2'd0 ? alu_a + alu_b :
                  alu_op == 2'd1 ? alu_a - alu_b :
                  alu_op == 2'd2 ? alu_a & alu_b : alu_a | alu_b;
    end

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return 8'((int'(a) + int'(b)) % 256);
            2'd1:    return 8'((int'(a) - int'(b) + 256) % 256);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // drive one cycle of inputs, account handshakes in the model, then advance to #1 after the edge
    task automatic step(input logic cv, input logic ld, input logic [1:0] op, input logic [7:0] d, input logic ordy);
        logic [7:0] e;
        bus.cmd_valid = cv;
        bus.cmd_load  = ld;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.out_ready = ordy;
        if (!rst) begin
            if (stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, held);
            end
            if (cv && bus.cmd_ready) begin
                acc_m = ld ? d : alu_ref(acc_m, d, op);
                exp_q.push_back(acc_m);
                n_acc++;
            end
            if (bus.out_valid && ordy) begin
                if (exp_q.size() == 0) check("spurious_rsp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_data", bus.out_data, e);
`ifdef SV_ALU_SEQ_FLAGS_EN
                    check("rsp_zero", bus.out_zero, e == 8'h00);
`endif
                end
                last_rsp = bus.out_data;
                n_rsp++;
            end
            stall = bus.out_valid && !ordy;
            held  = bus.out_data;
        end else stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 8'h00, 0);
        rst = 1'b0;
        exp_q.delete();
        acc_m = 8'h00;
    endtask

    task automatic drain(input int max);
        int k = 0;
        while ((exp_q.size() != 0 || bus.busy) && k < max) begin
            step(0, 0, 0, 8'h00, 1);
            k++;
        end
        check("drain_done", k < max, 1);
    endtask

    task automatic run_cmd(input logic ld, input logic [1:0] op, input logic [7:0] d);
        step(1, ld, op, d, 1);
        drain(20);
    endtask

    initial begin
        int start, r0, cyc, cnt;
        do_reset();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
`ifdef SV_ALU_SEQ_FLAGS_EN
        check("rst_out_zero", bus.out_zero, 1);
`endif
        // load then ADD: latency 3 from accept, and 3 from first response handshake
        step(1, 1, 2'd0, 8'h10, 0);
        check("lat_n1", bus.out_valid, 0);
        step(1, 0, 2'd0, 8'h05, 0);
        check("lat_n2", bus.out_valid, 0);
        step(0, 0, 0, 8'h00, 0);
        check("lat_n3", bus.out_valid, 1);
        check("load_data", bus.out_data, 8'h10);
        step(0, 0, 0, 8'h00, 1);
        check("lat2_n1", bus.out_valid, 0);
        step(0, 0, 0, 8'h00, 0);
        check("issue_alu_a", alu_a, 8'h10);
        check("issue_alu_b", alu_b, 8'h05);
        check("issue_alu_op", alu_op, 2'd0);
        step(0, 0, 0, 8'h00, 0);
        check("lat2_n3", bus.out_valid, 1);
        drain(20);
        check("add_rsp", last_rsp, 8'h15);
        // SUB wraps, then AND / OR
        run_cmd(0, 2'd1, 8'h20);
        check("sub_wrap", last_rsp, 8'hF5);
        run_cmd(0, 2'd2, 8'h0F);
        check("and_rsp", last_rsp, 8'h05);
        run_cmd(0, 2'd3, 8'hA0);
        check("or_rsp", last_rsp, 8'hA5);
        // stall: 1 in flight + 4 queued fills the FIFO
        r0 = n_rsp;
        step(1, 1, 2'd0, 8'h30, 0);
        step(1, 0, 2'd0, 8'h01, 0);
        step(1, 0, 2'd0, 8'h02, 0);
        step(1, 0, 2'd3, 8'h80, 0);
        check("ready_3q", bus.cmd_ready, 1);
        step(1, 0, 2'd2, 8'hF3, 0);
        check("full_ready", bus.cmd_ready, 0);
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, 8'h30);
        step(1, 1, 2'd0, 8'hEE, 0);
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("full_ready2", bus.cmd_ready, 0);
        drain(40);
        check("stall_rsp_cnt", n_rsp - r0, 5);
        check("stall_last", last_rsp, 8'hB3);
        // result of zero raises out_zero
        run_cmd(1, 2'd0, 8'h01);
        run_cmd(0, 2'd1, 8'h01);
        check("zero_rsp", last_rsp, 8'h00);
`ifdef SV_ALU_SEQ_FLAGS_EN
        check("zero_flag", bus.out_zero, 1);
`endif
        // reset while in ISSUE with two commands queued
        step(1, 1, 2'd0, 8'h44, 0);
        step(1, 0, 2'd0, 8'h01, 0);
        step(1, 0, 2'd0, 8'h02, 0);
        step(1, 0, 2'd0, 8'h03, 1);
        step(0, 0, 0, 8'h00, 0);
        check("pre_rst_busy", bus.busy, 1);
        do_reset();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_acc", alu_a, 0);
        check("mid_rst_ready", bus.cmd_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 8'h00, 1);
            if (bus.out_valid) cnt++;
        end
        check("post_rst_silent", cnt, 0);
        // random traffic against the model
        start = n_acc;
        r0    = n_rsp;
        cyc   = 0;
        while (n_acc - start < 10000 && cyc < 60000) begin
            step($urandom % 4 != 0, $urandom % 8 == 0, 2'($urandom), 8'($urandom), $urandom % 4 != 0);
            cyc++;
        end
        check("rand_accepted", n_acc - start, 10000);
        drain(100);
        check("rand_rsp_cnt", n_rsp - r0, n_acc - start);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
